// File: rtl/cpu_pkg.sv
// Shared CPU types and constants.
// Fetch-stage state, widths and branch offset helper.
package cpu_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(2);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

  // 10-bit signed word offset -> byte offset
  function automatic logic [ADDR_W-1:0] word_off(
    input logic [9:0] off
  );
    return {{(ADDR_W-11){off[9]}}, off, 1'b0};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory read bus.
// master = fetch stage, slave = memory.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic               mem_rd;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_rdata;
  logic               mem_ready;

  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_rdata,
    output mem_ready
  );

endinterface

// File: rtl/fetch_unit_pc_next.sv
// Next-PC adder and priority select.
// branch_en beats en_pc_2 beats plain step.
module pc_next_calc
  import cpu_pkg::*;
(
  input  logic [ADDR_W-1:0] pc,
  input  logic              en_pc_2,
  input  logic              branch_en,
  input  logic [9:0]        pc_offset,
  output logic [ADDR_W-1:0] pc_next
);

  always_comb begin
    pc_next = pc + PC_STEP;
    if (branch_en) begin
      pc_next = pc + PC_STEP + word_off(pc_offset);
    end else if (en_pc_2) begin
      pc_next = pc + PC_STEP + PC_STEP;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC,
// reads memory and holds the word for decode.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pc_inc,
  input  logic                en_pc_2,
  input  logic                branch_en,
  input  logic [9:0]          pc_offset,
  fetch_unit_if.master        mem,
  output logic [ADDR_W-1:0]   pc,
  output logic [INSTR_W-1:0]  instruction,
  output logic                inst_valid
);

  localparam logic [ADDR_W-1:0] PC_RST =
    RESET_PC & ~ADDR_W'(1);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  pc_next;

  pc_next_calc u_pc_next (
    .pc        (pc_q),
    .en_pc_2   (en_pc_2),
    .branch_en (branch_en),
    .pc_offset (pc_offset),
    .pc_next   (pc_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= PC_RST;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    mem.mem_rd = 1'b0;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ, WAIT: begin
        mem.mem_rd = 1'b1;
        if (mem.mem_ready) begin
          instr_d = mem.mem_rdata;
          valid_d = 1'b1;
          state_d = HOLD;
        end else begin
          state_d = WAIT;
        end
      end
      HOLD: begin
        if (pc_inc) begin
          pc_d    = pc_next & ~ADDR_W'(1);
          valid_d = 1'b0;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem.mem_addr = pc_q;
  assign pc           = pc_q;
  assign instruction  = instr_q;
  assign inst_valid   = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit
// against an arithmetic PC model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_inc = 1'b0;
  logic        en_pc_2 = 1'b0;
  logic        branch_en = 1'b0;
  logic [9:0]  pc_offset = '0;
  logic [15:0] pc;
  logic [15:0] instruction;
  logic        inst_valid;

  int total = 0;
  int passed = 0;
  int m_pc;
  logic [15:0] held;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(16'h0100)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_inc      (pc_inc),
    .en_pc_2     (en_pc_2),
    .branch_en   (branch_en),
    .pc_offset   (pc_offset),
    .mem         (bus),
    .pc          (pc),
    .instruction (instruction),
    .inst_valid  (inst_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic int model_next(int p, bit en2, bit br,
                                    logic [9:0] off);
    int so;
    so = off[9] ? int'(off) - 1024 : int'(off);
    if (br) return (p + 2 + 2 * so) & 32'hFFFF;
    if (en2) return (p + 4) & 32'hFFFF;
    return (p + 2) & 32'hFFFF;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    #1;
    m_pc = 16'h0100;
    chk("rst_pc", pc, m_pc);
    chk("rst_rd", bus.mem_rd, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_instr", instruction, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("idle_rd", bus.mem_rd, 0);
    @(negedge clk);
  endtask

  task automatic issue(bit en2, bit br, logic [9:0] off);
    pc_inc = 1'b1;
    en_pc_2 = en2;
    branch_en = br;
    pc_offset = off;
    m_pc = model_next(m_pc, en2, br, off);
    @(negedge clk);
    pc_inc = 1'b0;
    en_pc_2 = 1'b0;
    branch_en = 1'b0;
    pc_offset = 10'($urandom);
    chk("req_pc", pc, m_pc);
    chk("clr_valid", inst_valid, 0);
  endtask

  task automatic serve(int waits, logic [15:0] data, bit poke);
    chk("req_rd", bus.mem_rd, 1);
    chk("req_addr", bus.mem_addr, m_pc);
    for (int i = 0; i < waits; i++) begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 16'($urandom);
      if (poke) begin
        pc_inc = 1'b1;
        en_pc_2 = 1'($urandom);
        branch_en = 1'($urandom);
      end
      @(negedge clk);
      pc_inc = 1'b0;
      en_pc_2 = 1'b0;
      branch_en = 1'b0;
      chk("wait_rd", bus.mem_rd, 1);
      chk("wait_addr", bus.mem_addr, m_pc);
      chk("wait_pc", pc, m_pc);
      chk("wait_valid", inst_valid, 0);
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = data;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 16'($urandom);
    chk("cap_instr", instruction, data);
    chk("cap_valid", inst_valid, 1);
    chk("hold_rd", bus.mem_rd, 0);
  endtask

  task automatic hold(int n);
    held = instruction;
    for (int i = 0; i < n; i++) begin
      bus.mem_ready = 1'($urandom);
      bus.mem_rdata = 16'($urandom);
      en_pc_2 = 1'($urandom);
      branch_en = 1'($urandom);
      @(negedge clk);
      chk("hold_instr", instruction, held);
      chk("hold_rd", bus.mem_rd, 0);
      chk("hold_pc", pc, m_pc);
      chk("hold_valid", inst_valid, 1);
    end
    bus.mem_ready = 1'b0;
    en_pc_2 = 1'b0;
    branch_en = 1'b0;
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    @(negedge clk);

    // zero-wait fetch, then wait states and hold
    do_reset();
    serve(0, 16'h4A0B, 1'b0);
    issue(1'b0, 1'b0, 10'h000);
    serve(3, 16'h5123, 1'b0);
    hold(10);

    // sequential, skip, branch priority
    do_reset();
    serve(0, 16'h1111, 1'b0);
    issue(1'b0, 1'b0, 10'h000);
    chk("seq_pc", pc, 16'h0102);
    serve(1, 16'h2222, 1'b0);
    issue(1'b1, 1'b0, 10'h000);
    chk("skip_pc", pc, 16'h0106);
    serve(0, 16'h3333, 1'b0);
    issue(1'b1, 1'b1, 10'h005);
    chk("prio_pc", pc, 16'h0112);
    serve(2, 16'h4444, 1'b0);

    // jumps from 0x0100
    do_reset();
    serve(0, 16'h0001, 1'b0);
    issue(1'b0, 1'b1, 10'h005);
    chk("jmp_fwd", pc, 16'h010C);
    serve(0, 16'h0002, 1'b0);
    do_reset();
    serve(0, 16'h0003, 1'b0);
    issue(1'b0, 1'b1, 10'h3FE);
    chk("jmp_back", pc, 16'h00FE);
    serve(0, 16'h0004, 1'b0);
    do_reset();
    serve(0, 16'h0005, 1'b0);
    issue(1'b0, 1'b1, 10'h200);
    chk("jmp_wrap", pc, 16'hFD02);
    serve(1, 16'h0006, 1'b0);

    // wrap at top, pc_inc ignored during WAIT
    do_reset();
    serve(0, 16'h0007, 1'b0);
    issue(1'b0, 1'b1, 10'h37E);
    chk("to_top", pc, 16'hFFFE);
    serve(0, 16'h0008, 1'b0);
    issue(1'b0, 1'b0, 10'h000);
    chk("wrap_pc", pc, 16'h0000);
    chk("wrap_addr", bus.mem_addr, 16'h0000);
    serve(3, 16'h0009, 1'b1);
    hold(4);

    // asynchronous reset mid-WAIT
    do_reset();
    serve(0, 16'h000A, 1'b0);
    issue(1'b0, 1'b1, 10'h07F);
    chk("to_200", pc, 16'h0200);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("in_wait", bus.mem_rd, 1);
    #2;
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 16'hDEAD;
    #1;
    chk("arst_rd", bus.mem_rd, 0);
    chk("arst_valid", inst_valid, 0);
    chk("arst_pc", pc, 16'h0100);
    @(negedge clk);
    chk("arst_nocap", instruction, 0);
    bus.mem_ready = 1'b0;
    rst = 1'b1;
    m_pc = 16'h0100;
    @(negedge clk);
    serve(1, 16'h000B, 1'b0);

    // randomized fetch stream
    for (int k = 0; k < 40; k++) begin
      int w;
      w = int'($urandom_range(0, 3));
      issue(1'($urandom), 1'($urandom), 10'($urandom));
      serve(w, 16'($urandom), 1'($urandom));
      if ((k % 8) == 0) hold(2);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
